// File: rtl/gaussian_pkg.sv
// Shared constants for the 7x7 Gaussian window generator and the Gaussian core.
package gaussian_pkg;
  localparam int KERNEL    = 7;
  localparam int PIX_W     = 8;
  localparam int WIN_BITS  = KERNEL * KERNEL * PIX_W;
  localparam int NUM_LINES = KERNEL - 1;

  // Bit offset of window slot (i, j) in the packed window bus.
  function automatic int slot_lsb(input int i, input int j);
    return PIX_W * (KERNEL * i + j);
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One-line pixel delay in inferred block RAM, addressed by column.
// The read port is prefetched with the next column so dout is valid when that column is accepted.
module line_buffer
  import gaussian_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             in_valid,
  input  logic [AW-1:0]    wr_addr,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; exposed windows only use data written in the current frame.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_addr] <= din;
    end
    dout <= mem[rd_addr];
  end

endmodule

// File: rtl/gaussian_window_gen.sv
// Raster-scan 7x7 window generator: six chained line buffers feed a shifting 7x7 register array.
module gaussian_window_gen
  import gaussian_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                in_valid,
  input  logic [PIX_W-1:0]    in_pixel,
  output logic                window_valid,
  output logic [WIN_BITS-1:0] window_pixels,
  output logic                frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_reg, cur_col, col_next;
  logic [RW-1:0] row_reg, cur_row, row_next;
  logic          win_ok, last_pix;

  // cur_* is the position of the pixel on the input this cycle, *_next the one after it.
  always_comb begin
    cur_col  = frame_start ? '0 : col_reg;
    cur_row  = frame_start ? '0 : row_reg;
    col_next = col_reg;
    row_next = row_reg;
    if (in_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_next = '0;
        row_next = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_next = cur_col + CW'(1);
        row_next = cur_row;
      end
    end else if (frame_start) begin
      col_next = '0;
      row_next = '0;
    end
  end

  assign win_ok   = (cur_row >= RW'(KERNEL - 1)) && (cur_col >= CW'(KERNEL - 1));
  assign last_pix = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg      <= '0;
      row_reg      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      col_reg      <= col_next;
      row_reg      <= row_next;
      window_valid <= in_valid && win_ok;
      frame_done   <= in_valid && last_pix;
    end
  end

  // taps[k] is pixel (r-k, c) for the pixel currently being accepted.
  logic [NUM_LINES:0][PIX_W-1:0] taps;
  assign taps[0] = in_pixel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W),
        .AW    (CW)
      ) u_line (
        .clk      (clk),
        .in_valid (in_valid),
        .wr_addr  (cur_col),
        .rd_addr  (col_next),
        .din      (taps[gi]),
        .dout     (taps[gi+1])
      );
    end

    // Each window row is a 7-pixel shift register; element j is column j from the left.
    for (gi = 0; gi < KERNEL; gi++) begin : g_row
      logic [KERNEL-1:0][PIX_W-1:0] win_row_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          win_row_reg <= '0;
        end else if (in_valid) begin
          win_row_reg <= {taps[KERNEL-1-gi], win_row_reg[KERNEL-1:1]};
        end
      end

      assign window_pixels[slot_lsb(gi, 0) +: KERNEL*PIX_W] = win_row_reg;
    end
  endgenerate

endmodule
